// File: rtl/riscv_ctrl_pkg.sv
// riscv_ctrl_pkg: opcodes, FSM states, fault codes and ALU codes shared by the multicycle controller
package riscv_ctrl_pkg;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [2:0] F3_WORD   = 3'b010;
  localparam logic [3:0] ALU_ADD   = 4'b0000;
  localparam logic [3:0] ALU_SUB   = 4'b1000;
  localparam logic [1:0] FLT_NONE  = 2'b00;
  localparam logic [1:0] FLT_ILL   = 2'b01;
  localparam logic [1:0] FLT_IMEM  = 2'b10;
  localparam logic [1:0] FLT_DMEM  = 2'b11;
  typedef enum logic [1:0] {S_FETCH, S_EXEC, S_MEM, S_TRAP} state_t;
endpackage

// File: rtl/ctrl_decode.sv
// ctrl_decode: combinational RV32I-subset decoder
// in: instr; out: immediate-format flags, alusrc, regwrite (ALU types), alucontrol, illegal, is_load, is_store
module ctrl_decode
  import riscv_ctrl_pkg::*;
(
  input  logic [31:0] instr,
  output logic        i_op,
  output logic        s_op,
  output logic        b_op,
  output logic        u_op,
  output logic        j_op,
  output logic        alusrc,
  output logic        regwrite,
  output logic        illegal,
  output logic        is_load,
  output logic        is_store,
  output logic [3:0]  alucontrol
);
  logic [6:0] op;
  logic [2:0] f3;
  logic       r_t, ia_t, lui_t, jal_t, br_t;
  logic       unused_bits;
  assign op          = instr[6:0];
  assign f3          = instr[14:12];
  assign unused_bits = ^{instr[31], instr[29:15], instr[11:7]};
  assign r_t         = op == OP_R;
  assign ia_t        = op == OP_IMM;
  assign lui_t       = op == OP_LUI;
  assign jal_t       = op == OP_JAL;
  // funct3 010/011 are not branch encodings
  assign br_t        = op == OP_BRANCH && f3[2:1] != 2'b01;
  assign is_load     = op == OP_LOAD && f3 == F3_WORD;
  assign is_store    = op == OP_STORE && f3 == F3_WORD;
  assign illegal     = !(r_t || ia_t || lui_t || jal_t || br_t || is_load || is_store);
  assign i_op        = ia_t || is_load;
  assign s_op        = is_store;
  assign b_op        = br_t;
  assign u_op        = lui_t;
  assign j_op        = jal_t;
  assign alusrc      = ia_t || lui_t || is_load || is_store;
  assign regwrite    = r_t || ia_t || lui_t || jal_t;
  // instr[30] only selects SRA/SRAI-style variants for shift-right immediates
  assign alucontrol  = r_t  ? {instr[30], f3} :
                       ia_t ? {f3 == 3'b101 && instr[30], f3} :
                       br_t ? (ALU_SUB | {1'b0, f3}) : ALU_ADD;
endmodule

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: FETCH/EXEC/MEM/TRAP sequencer with req/ack memories, ack timeout and retire counter
// in: clk, reset (sync, active-low), instr, btaken, imem_ack, dmem_ack; out: memory reqs, enables, datapath controls, fault, instret
module multicycle_ctrl
  import riscv_ctrl_pkg::*;
#(
  parameter int ACK_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instr,
  input  logic        btaken,
  input  logic        imem_ack,
  input  logic        dmem_ack,
  output logic        imem_req,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic        ir_en,
  output logic        pc_en,
  output logic        memtoreg,
  output logic        pcsrc,
  output logic        alusrc,
  output logic        regwrite,
  output logic        i_op,
  output logic        s_op,
  output logic        b_op,
  output logic        u_op,
  output logic        j_op,
  output logic [3:0]  alucontrol,
  output logic [1:0]  fault,
  output logic [31:0] instret
);
  // a req gets at most ACK_TIMEOUT cycles, the last one still accepting ack
  localparam logic [7:0] LAST_WAIT = 8'(ACK_TIMEOUT - 1);
  state_t      state_q, state_d;
  logic [1:0]  fault_q, fault_d;
  logic [7:0]  wait_q, wait_d;
  logic [31:0] instret_q;
  logic        retire, drive, timeout;
  logic        d_i, d_s, d_b, d_u, d_j, d_alusrc, d_rw, d_ill, d_ld, d_st;
  logic [3:0]  d_alu;
  ctrl_decode u_dec (
    .instr(instr), .i_op(d_i), .s_op(d_s), .b_op(d_b), .u_op(d_u), .j_op(d_j),
    .alusrc(d_alusrc), .regwrite(d_rw), .illegal(d_ill), .is_load(d_ld),
    .is_store(d_st), .alucontrol(d_alu)
  );
  assign timeout = wait_q == LAST_WAIT;
  always_comb begin
    state_d  = state_q;
    fault_d  = fault_q;
    retire   = 1'b0;
    ir_en    = 1'b0;
    pc_en    = 1'b0;
    regwrite = 1'b0;
    memtoreg = 1'b0;
    pcsrc    = 1'b0;
    case (state_q)
      S_FETCH: begin
        if (imem_ack) begin
          ir_en   = 1'b1;
          state_d = S_EXEC;
        end else if (timeout) begin
          state_d = S_TRAP;
          fault_d = FLT_IMEM;
        end
      end
      S_EXEC: begin
        if (d_ill) begin
          state_d = S_TRAP;
          fault_d = FLT_ILL;
        end else if (d_ld || d_st) begin
          state_d = S_MEM;
        end else begin
          pc_en    = 1'b1;
          retire   = 1'b1;
          regwrite = d_rw;
          pcsrc    = d_b && btaken;
          state_d  = S_FETCH;
        end
      end
      S_MEM: begin
        if (dmem_ack) begin
          regwrite = d_ld;
          memtoreg = d_ld;
          pc_en    = 1'b1;
          retire   = 1'b1;
          state_d  = S_FETCH;
        end else if (timeout) begin
          state_d = S_TRAP;
          fault_d = FLT_DMEM;
        end
      end
      default: ;
    endcase
    if (!reset) {ir_en, pc_en, regwrite, memtoreg, pcsrc, retire} = '0;
  end
  // the wait counter restarts whenever the state changes
  assign wait_d = state_d == state_q ? wait_q + 8'd1 : 8'd0;
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= S_FETCH;
      fault_q   <= FLT_NONE;
      wait_q    <= '0;
      instret_q <= '0;
    end else begin
      state_q   <= state_d;
      fault_q   <= fault_d;
      wait_q    <= wait_d;
      instret_q <= instret_q + {31'd0, retire};
    end
  end
  // decode controls are shown in EXEC (legal only) and held through MEM
  assign drive      = reset && (state_q == S_MEM || (state_q == S_EXEC && !d_ill));
  assign imem_req   = reset && state_q == S_FETCH;
  assign dmem_req   = reset && state_q == S_MEM;
  assign dmem_we    = dmem_req && d_st;
  assign {i_op, s_op, b_op, u_op, j_op, alusrc} = drive ? {d_i, d_s, d_b, d_u, d_j, d_alusrc} : 6'd0;
  assign alucontrol = drive ? d_alu : ALU_ADD;
  assign fault      = reset ? fault_q : FLT_NONE;
  assign instret    = reset ? instret_q : 32'd0;
endmodule
